// File: rtl/sys_ce_reset_gen.sv
// System reset sequencer (power-on hold, request stretch) plus NUM_CE
// programmable clock-enable channels that keep running while the core is in reset.
module sys_ce_reset_gen #(
    parameter int unsigned NUM_CE      = 2,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned POR_CYCLES  = 20000000,
    parameter int unsigned RST_STRETCH = 15,
    parameter int unsigned DIV_INIT    = 49,
    parameter int unsigned PHASE_INIT  = 8
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [NUM_SRC-1:0]      rst_req,
    input  logic [NUM_CE*DIV_W-1:0] div,
    input  logic [NUM_CE*DIV_W-1:0] phase,
    input  logic                    div_load,
    input  logic                    pause,
    output logic                    sys_reset,
    output logic                    por_done,
    output logic [NUM_CE-1:0]       ce
);

    localparam int unsigned POR_W  = $clog2(POR_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(RST_STRETCH + 1);

    typedef enum logic [1:0] {ST_POR, ST_HOLD, ST_RUN} state_t;

    state_t              state, state_nxt;
    logic [POR_W-1:0]    por_cnt, por_cnt_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic                por_done_nxt, sys_reset_nxt;
    logic                req_any;

    logic [DIV_W-1:0]    cnt    [NUM_CE];
    logic [DIV_W-1:0]    d_sh   [NUM_CE];
    logic [DIV_W-1:0]    p_sh   [NUM_CE];
    logic [DIV_W-1:0]    eff_ph [NUM_CE];

    assign req_any = |rst_req;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_POR;
            por_cnt   <= '0;
            hold_cnt  <= '0;
            por_done  <= 1'b0;
            sys_reset <= 1'b1;
        end else begin
            state     <= state_nxt;
            por_cnt   <= por_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            por_done  <= por_done_nxt;
            sys_reset <= sys_reset_nxt;
        end
    end

    // sys_reset is registered from the next state, so it drops on the edge entering RUN
    always_comb begin
        state_nxt     = state;
        por_cnt_nxt   = por_cnt;
        hold_cnt_nxt  = hold_cnt;
        por_done_nxt  = por_done;
        sys_reset_nxt = 1'b1;
        case (state)
            ST_POR: begin
                if (por_cnt == POR_W'(POR_CYCLES - 1)) begin
                    state_nxt    = ST_HOLD;
                    por_cnt_nxt  = '0;
                    hold_cnt_nxt = '0;
                    por_done_nxt = 1'b1;
                end else begin
                    por_cnt_nxt = por_cnt + POR_W'(1);
                end
            end
            ST_HOLD: begin
                if (req_any) begin
                    hold_cnt_nxt = '0;
                end else if (hold_cnt == HOLD_W'(RST_STRETCH - 1)) begin
                    state_nxt     = ST_RUN;
                    hold_cnt_nxt  = '0;
                    sys_reset_nxt = 1'b0;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                sys_reset_nxt = 1'b0;
                if (req_any) begin
                    state_nxt     = ST_HOLD;
                    hold_cnt_nxt  = '0;
                    sys_reset_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_POR;
            end
        endcase
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_CE; k++) begin
            eff_ph[k] = (p_sh[k] < d_sh[k]) ? p_sh[k] : d_sh[k];
        end
    end

    // Wrap on >= so a shadow divisor below the current count cannot run away
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ce <= '0;
            for (int unsigned k = 0; k < NUM_CE; k++) begin
                cnt[k]  <= '0;
                d_sh[k] <= DIV_W'(DIV_INIT);
                p_sh[k] <= DIV_W'(PHASE_INIT);
            end
        end else if (div_load) begin
            ce <= '0;
            for (int unsigned k = 0; k < NUM_CE; k++) begin
                cnt[k]  <= '0;
                d_sh[k] <= div[k*DIV_W +: DIV_W];
                p_sh[k] <= phase[k*DIV_W +: DIV_W];
            end
        end else if (pause) begin
            ce <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CE; k++) begin
                ce[k]  <= (cnt[k] == eff_ph[k]);
                cnt[k] <= (cnt[k] >= d_sh[k]) ? '0 : cnt[k] + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sys_ce_reset_gen.sv
// Scoreboarded bench for sys_ce_reset_gen with a short power-on hold and stretch.
`timescale 1ns/1ps
module tb_sys_ce_reset_gen;

    localparam int NCE  = 2;
    localparam int DW   = 8;
    localparam int NS   = 4;
    localparam int PORC = 16;
    localparam int STR  = 4;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic [NS-1:0]     rst_req;
    logic [NCE*DW-1:0] div;
    logic [NCE*DW-1:0] phase;
    logic              div_load;
    logic              pause;
    logic              sys_reset;
    logic              por_done;
    logic [NCE-1:0]    ce;

    always #5 clk_sys = ~clk_sys;

    sys_ce_reset_gen #(
        .NUM_CE     (NCE),
        .DIV_W      (DW),
        .NUM_SRC    (NS),
        .POR_CYCLES (PORC),
        .RST_STRETCH(STR)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .rst_req  (rst_req),
        .div      (div),
        .phase    (phase),
        .div_load (div_load),
        .pause    (pause),
        .sys_reset(sys_reset),
        .por_done (por_done),
        .ce       (ce)
    );

    typedef struct packed {
        logic       sr;
        logic       pd;
        logic [1:0] ce;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc;
    int   first_ce0;

    int         m_st, m_por, m_hold;
    logic       m_pd, m_sr;
    logic [1:0] m_ce;
    int         m_cnt [NCE];
    int         m_d   [NCE];
    int         m_p   [NCE];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_por = 0; m_hold = 0;
        m_pd = 1'b0; m_sr = 1'b1; m_ce = '0;
        for (int k = 0; k < NCE; k++) begin
            m_cnt[k] = 0; m_d[k] = 49; m_p[k] = 8;
        end
    endtask

    // One clock: predict outputs from the current inputs, then compare after the edge
    task automatic step();
        exp_t e;
        int   eff;
        if (m_st == 0) begin
            m_por++;
            if (m_por == PORC) begin m_st = 1; m_pd = 1'b1; m_hold = 0; end
        end else if (m_st == 1) begin
            if (rst_req != 0) m_hold = 0;
            else begin
                m_hold++;
                if (m_hold == STR) m_st = 2;
            end
        end else if (rst_req != 0) begin
            m_st = 1; m_hold = 0;
        end
        m_sr = (m_st != 2);
        for (int k = 0; k < NCE; k++) begin
            if (div_load) begin
                m_d[k] = int'(div[k*DW +: DW]);
                m_p[k] = int'(phase[k*DW +: DW]);
                m_cnt[k] = 0; m_ce[k] = 1'b0;
            end else if (pause) begin
                m_ce[k] = 1'b0;
            end else begin
                eff = (m_p[k] < m_d[k]) ? m_p[k] : m_d[k];
                m_ce[k] = (m_cnt[k] == eff);
                m_cnt[k] = (m_cnt[k] == m_d[k]) ? 0 : m_cnt[k] + 1;
            end
        end
        e.sr = m_sr; e.pd = m_pd; e.ce = m_ce;
        sb.push_back(e);
        @(posedge clk_sys);
        #1;
        if (sb.size() == 0) chk("sb_empty", 0, 1);
        else begin
            e = sb.pop_front();
            chk("outs", int'({sys_reset, por_done, ce}), int'(e));
        end
        cyc++;
        if (ce[0] && first_ce0 < 0) first_ce0 = cyc;
    endtask

    function automatic bit hit(input int what);
        case (what)
            0:       return por_done;
            1:       return !sys_reset;
            2:       return ce[0];
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_until(input int what, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!hit(what) && n < limit);
        if (!hit(what)) chk("timeout", 0, 1);
    endtask

    int n, cnt_p, total;

    initial begin
        reset_n = 1'b0; rst_req = '0; div = '0; phase = '0;
        div_load = 1'b0; pause = 1'b0;
        cyc = 0; first_ce0 = -1;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_sr", int'(sys_reset), 1);
        chk("rst_pd", int'(por_done), 0);
        chk("rst_ce", int'(ce), 0);
        #1 reset_n = 1'b1;

        // Power-on hold, stretch and default channel timing
        run_until(0, 100, n);
        chk("por_lat", n, PORC);
        run_until(1, 100, n);
        chk("rel_lat", n, STR);
        chk("ce0_first", first_ce0, 9);
        run_until(2, 200, n);
        chk("ce0_second", cyc, 59);
        run_until(2, 200, n);
        chk("ce0_period", n, 50);

        // Single request, then a request that lands at quiet count 3
        rst_req = 4'b0100; step(); rst_req = '0;
        chk("req_sr", int'(sys_reset), 1);
        run_until(1, 100, n);
        chk("req_hold", n, STR);
        rst_req = 4'b0100; step(); rst_req = '0;
        total = 1;
        repeat (3) begin step(); total++; end
        rst_req = 4'b0001; step(); rst_req = '0;
        total++;
        run_until(1, 100, n);
        chk("req_ext_tail", n, STR);
        chk("req_ext_total", total + n - 1, 2 * STR);

        // Reload: ch1 div=0 phase=5, ch0 div=3 phase=7
        div = {8'd0, 8'd3}; phase = {8'd5, 8'd7}; div_load = 1'b1;
        step(); div_load = 1'b0;
        chk("ld_ce", int'(ce), 0);
        step();
        chk("ch1_first", int'(ce[1]), 1);
        run_until(2, 20, n);
        chk("ch0_first", n, 3);
        div = {8'd77, 8'd77}; phase = {8'd1, 8'd1};
        rst_req = 4'b1000;
        run_until(2, 20, n);
        rst_req = '0;
        chk("ch0_period4", n, 4);
        run_until(2, 20, n);
        chk("ch0_noload", n, 4);

        // Pause mid-period with ch0 D=9, P=2
        div = {8'd0, 8'd9}; phase = {8'd0, 8'd2}; div_load = 1'b1;
        step(); div_load = 1'b0;
        repeat (5) step();
        pause = 1'b1; cnt_p = 0;
        repeat (23) begin step(); cnt_p += int'(ce[0]) + int'(ce[1]); end
        chk("pause_ce", cnt_p, 0);
        pause = 1'b0;
        run_until(2, 40, n);
        chk("pause_resume", n, 8);
        run_until(2, 40, n);
        chk("pause_period", n, 10);

        // Load while paused keeps counters at zero until release
        pause = 1'b1; div_load = 1'b1;
        step(); div_load = 1'b0;
        repeat (4) step();
        chk("ldp_ce", int'(ce), 0);
        pause = 1'b0;
        run_until(2, 40, n);
        chk("ldp_first", n, 3);

        // Asynchronous reset mid-RUN with enables active
        repeat (2) step();
        reset_n = 1'b0;
        #1;
        chk("arst_sr", int'(sys_reset), 1);
        chk("arst_pd", int'(por_done), 0);
        chk("arst_ce", int'(ce), 0);
        @(posedge clk_sys);
        #2 reset_n = 1'b1;
        sb.delete();
        model_reset();
        cyc = 0; first_ce0 = -1;
        run_until(0, 100, n);
        chk("por_restart", n, PORC);
        run_until(1, 100, n);
        chk("rel_restart", n, STR);
        chk("ce0_restart", first_ce0, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
